efuse_read: RTL and testbench



---
 rtl/efuse_pkg.sv | 30 +++
 rtl/efuse_pulse_timer.sv | 27 ++
 rtl/efuse_read.sv | 126 ++++++++++++
 tb/tb_efuse_read.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// Shared eFuse definitions: macro geometry, read FSM state type, timing helpers.
package efuse_pkg;

  localparam int EFUSE_BITS   = 256;
  localparam int EFUSE_AW     = 8;
  localparam int AENL_CYC_DEF = 4;
  localparam int TMR_W        = 10;

  // Read-path FSM states; the write path keeps its own enum type.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    AEN_H = 2'd2,
    AEN_L = 2'd3
  } efuse_rd_state_e;

  // Terminal count for the AEN high phase: max(trd,1)-1.
  function automatic logic [TMR_W-1:0] trd_term(input logic [TMR_W-1:0] trd);
    return (trd == '0) ? '0 : trd - 1'b1;
  endfunction

  // First fuse address of word 'sel' for 'nw'-bit words, 8-bit result.
  function automatic logic [EFUSE_AW-1:0] word_base(input int unsigned nw,
                                                    input int unsigned sel);
    int unsigned prod;
    prod = nw * sel;
    return prod[EFUSE_AW-1:0];
  endfunction

endpackage

// File: rtl/efuse_pulse_timer.sv
// Generic 10-bit cycle counter with synchronous clear, enable and a
// terminal-count flag; shared by the eFuse read and write sequencers.
module efuse_pulse_timer
  import efuse_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] term,
  output logic             tc
);

  logic [TMR_W-1:0] cnt;

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/efuse_read.sv
// eFuse read controller: walks the NW bit addresses of one word, strobes AEN
// per bit and assembles the sampled DOUT bits into read_data.
// Optional build macro EFUSE_RD_AUTOLOAD_EN: when defined, word 0 is read
// automatically once after every reset release.
module efuse_read
  import efuse_pkg::*;
#(
  parameter  int NW       = 64,
  parameter  int WSEL     = EFUSE_BITS / NW,
  parameter  int AENL_CYC = AENL_CYC_DEF,
  localparam int SEL_W    = (WSEL > 1) ? $clog2(WSEL) : 1,
  localparam int BIT_W    = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TMR_W-1:0]    rg_efuse_trd,
  input  logic [SEL_W-1:0]    read_sel,
  input  logic                read_start,
  output logic [NW-1:0]       read_data,
  output logic                read_done,
  output logic                busy_read,
  input  logic                efuse_dout_i,
  output logic                efuse_pgmen_o,
  output logic                efuse_rden_o,
  output logic                efuse_aen_o,
  output logic [EFUSE_AW-1:0] efuse_addr_o
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NW - 1);
  localparam logic [TMR_W-1:0] AENL_TERM = TMR_W'(AENL_CYC - 1);

  efuse_rd_state_e  state;
  logic [BIT_W-1:0] bit_idx;
  logic             start_req;
  logic [SEL_W-1:0] sel_eff;
  logic             tmr_clr;
  logic [TMR_W-1:0] tmr_term;
  logic             tmr_tc;

`ifdef EFUSE_RD_AUTOLOAD_EN
  logic             autoload_pend;

  // Pending autoload behaves like a start request for word 0.
  always_comb begin
    start_req = read_start | autoload_pend;
    sel_eff   = autoload_pend ? '0 : read_sel;
  end
`else
  // Only an explicit request starts a read.
  always_comb begin
    start_req = read_start;
    sel_eff   = read_sel;
  end
`endif

  // The timer restarts on every phase change and is held clear while idle.
  assign tmr_clr  = (state == IDLE) || (state == SETUP) || tmr_tc;
  assign tmr_term = (state == AEN_H) ? trd_term(rg_efuse_trd) : AENL_TERM;

  efuse_pulse_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (1'b1),
    .term (tmr_term),
    .tc   (tmr_tc)
  );

  // Read sequencer: accept, RDEN setup, then AEN high/low per bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      read_data    <= '0;
      read_done    <= 1'b0;
      efuse_addr_o <= '0;
      bit_idx      <= '0;
`ifdef EFUSE_RD_AUTOLOAD_EN
      autoload_pend <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start_req) begin
            efuse_addr_o <= word_base(NW, 32'(sel_eff));
            bit_idx      <= '0;
            read_data    <= '0;
            read_done    <= 1'b0;
            state        <= SETUP;
`ifdef EFUSE_RD_AUTOLOAD_EN
            autoload_pend <= 1'b0;
`endif
          end
        end
        SETUP: begin
          state <= AEN_H;
        end
        AEN_H: begin
          if (tmr_tc) begin
            read_data[bit_idx] <= efuse_dout_i;
            state              <= AEN_L;
          end
        end
        AEN_L: begin
          if (tmr_tc) begin
            if (bit_idx == LAST_BIT) begin
              read_done    <= 1'b1;
              efuse_addr_o <= '0;
              state        <= IDLE;
            end else begin
              bit_idx      <= bit_idx + 1'b1;
              efuse_addr_o <= efuse_addr_o + 1'b1;
              state        <= AEN_H;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_read     = (state != IDLE);
  assign efuse_rden_o  = (state != IDLE);
  assign efuse_aen_o   = (state == AEN_H);
  assign efuse_pgmen_o = 1'b0;

endmodule

// File: tb/tb_efuse_read.sv
// Directed self-checking bench for efuse_read with a behavioural fuse array.
`timescale 1ns/1ps
module tb_efuse_read;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rg_efuse_trd;
  logic [1:0]  read_sel;
  logic        read_start;
  logic [63:0] read_data;
  logic        read_done;
  logic        busy_read;
  logic        efuse_dout_i;
  logic        efuse_pgmen_o;
  logic        efuse_rden_o;
  logic        efuse_aen_o;
  logic [7:0]  efuse_addr_o;

  logic fuse [256];
  assign efuse_dout_i = fuse[efuse_addr_o];

  int n_cmp = 0;
  int n_bad = 0;

  // monitor controls (written by the stimulus only)
  logic mon_clr = 1'b0;
  int   exp_aen_len = 1;
  // monitor tallies (written by the monitor only)
  int   run = 0, aen_pulses = 0, aen_bad = 0, done_rises = 0, pgmen_seen = 0;
  int   addr_min = 255, addr_max = 0;
  logic prev_done = 1'b0;

  efuse_read dut (
    .clk           (clk),
    .rst           (rst),
    .rg_efuse_trd  (rg_efuse_trd),
    .read_sel      (read_sel),
    .read_start    (read_start),
    .read_data     (read_data),
    .read_done     (read_done),
    .busy_read     (busy_read),
    .efuse_dout_i  (efuse_dout_i),
    .efuse_pgmen_o (efuse_pgmen_o),
    .efuse_rden_o  (efuse_rden_o),
    .efuse_aen_o   (efuse_aen_o),
    .efuse_addr_o  (efuse_addr_o)
  );

  always #5 clk = ~clk;

  // Tally AEN pulse lengths, strobed addresses, done edges on the falling edge.
  always @(negedge clk) begin
    if (mon_clr) begin
      run = 0; aen_pulses = 0; aen_bad = 0; done_rises = 0; pgmen_seen = 0;
      addr_min = 255; addr_max = 0; prev_done = read_done;
    end else begin
      if (efuse_aen_o) begin
        run++;
        if (int'(efuse_addr_o) < addr_min) addr_min = int'(efuse_addr_o);
        if (int'(efuse_addr_o) > addr_max) addr_max = int'(efuse_addr_o);
      end else if (run != 0) begin
        aen_pulses++;
        if (run != exp_aen_len) aen_bad++;
        run = 0;
      end
      if (read_done && !prev_done) done_rises++;
      prev_done = read_done;
      if (efuse_pgmen_o) pgmen_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fuse_clear();
    for (int i = 0; i < 256; i++) fuse[i] = 1'b0;
  endtask

  task automatic fuse_word0();
    fuse_clear();
    fuse[0] = 1'b1; fuse[5] = 1'b1; fuse[63] = 1'b1;
  endtask

  task automatic fuse_word1();
    fuse_clear();
    fuse[64] = 1'b1; fuse[65] = 1'b1; fuse[100] = 1'b1; fuse[127] = 1'b1;
  endtask

  // Launch one read and count clock edges starting with the accept edge (=1);
  // lat is that count when read_done is first seen high, -1 if never.
  // abort_at asserts rst after edge abort_at; pulse_at pulses start(sel=2).
  task automatic run_read(input logic [1:0] sel, input logic [9:0] trd,
                          input int aen_len, input int abort_at, input int pulse_at,
                          output int lat, output logic done_at1, output logic busy_at1);
    int n;
    exp_aen_len = aen_len;
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
    read_sel = sel; rg_efuse_trd = trd; read_start = 1'b1;
    n = 0; lat = -1; done_at1 = 1'bx; busy_at1 = 1'bx;
    while (n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin read_start = 1'b0; done_at1 = read_done; busy_at1 = busy_read; end
      if (pulse_at > 0 && n == pulse_at) begin read_start = 1'b1; read_sel = 2'd2; end
      if (pulse_at > 0 && n == pulse_at + 1) read_start = 1'b0;
      if (abort_at > 0 && n == abort_at) begin rst = 1'b1; break; end
      if (read_done) begin lat = n; break; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy_read; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; read_start = 1'b0; read_sel = 2'd0; rg_efuse_trd = 10'd2;
    fuse_word0();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy_read !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_read); end
    n_cmp++; if ({efuse_rden_o, efuse_aen_o, efuse_pgmen_o} !== 3'b000) begin n_bad++; $display("FAIL reset_pins: rden/aen/pgmen got %b want 000", {efuse_rden_o, efuse_aen_o, efuse_pgmen_o}); end
    n_cmp++; if (efuse_addr_o !== 8'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", efuse_addr_o); end
    n_cmp++; if (read_data !== 64'd0 || read_done !== 1'b0) begin n_bad++; $display("FAIL reset_data: data %h done %b want 0/0", read_data, read_done); end
  endtask

`ifdef EFUSE_RD_AUTOLOAD_EN
  task automatic test_autoload();
    int n, lat;
    logic busy1;
    exp_aen_len = 2;
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0; rst = 1'b0; read_start = 1'b0; rg_efuse_trd = 10'd2;
    n = 0; lat = -1; busy1 = 1'bx;
    while (n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) busy1 = busy_read;
      if (n == 20) begin read_start = 1'b1; read_sel = 2'd3; end
      if (n == 21) read_start = 1'b0;
      if (read_done) begin lat = n; break; end
    end
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL autoload_busy: got %b want 1", busy1); end
    n_cmp++; if (lat !== 386) begin n_bad++; $display("FAIL autoload_latency: got %0d want 386", lat); end
    n_cmp++; if (read_data !== 64'h8000_0000_0000_0021) begin n_bad++; $display("FAIL autoload_data: got %h want 8000000000000021", read_data); end
    n_cmp++; if (addr_max !== 63) begin n_bad++; $display("FAIL autoload_addr_max: got %0d want 63", addr_max); end
  endtask
`else
  task automatic test_no_autoload();
    int busy_cnt;
    @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy_read || efuse_rden_o || read_done) busy_cnt++;
    end
    n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL no_autoload_busy: got %0d busy cycles want 0", busy_cnt); end
  endtask
`endif

  task automatic test_read_word0();
    int lat; logic d1, b1;
    fuse_word0();
    run_read(2'd0, 10'd2, 2, 0, 0, lat, d1, b1);
    n_cmp++; if (lat !== 386) begin n_bad++; $display("FAIL word0_latency: got %0d want 386", lat); end
    n_cmp++; if (read_data !== 64'h8000_0000_0000_0021) begin n_bad++; $display("FAIL word0_data: got %h want 8000000000000021", read_data); end
    n_cmp++; if (aen_pulses !== 64 || aen_bad !== 0) begin n_bad++; $display("FAIL word0_aen: pulses %0d badlen %0d want 64/0", aen_pulses, aen_bad); end
    n_cmp++; if (addr_min !== 0 || addr_max !== 63) begin n_bad++; $display("FAIL word0_addr_range: got %0d..%0d want 0..63", addr_min, addr_max); end
    n_cmp++; if (b1 !== 1'b1 || busy_read !== 1'b0) begin n_bad++; $display("FAIL word0_busy: at accept %b at done %b want 1/0", b1, busy_read); end
    n_cmp++; if (pgmen_seen !== 0) begin n_bad++; $display("FAIL word0_pgmen: got %0d cycles want 0", pgmen_seen); end
  endtask

  task automatic test_read_word3();
    int lat; logic d1, b1;
    fuse_clear();
    for (int i = 192; i < 256; i++) fuse[i] = 1'b1;
    run_read(2'd3, 10'd10, 10, 0, 0, lat, d1, b1);
    n_cmp++; if (lat !== 898) begin n_bad++; $display("FAIL word3_latency: got %0d want 898", lat); end
    n_cmp++; if (read_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL word3_data: got %h want all ones", read_data); end
    n_cmp++; if (addr_min !== 192 || addr_max !== 255) begin n_bad++; $display("FAIL word3_addr_range: got %0d..%0d want 192..255", addr_min, addr_max); end
    n_cmp++; if (efuse_addr_o !== 8'd0) begin n_bad++; $display("FAIL word3_addr_after: got %0d want 0", efuse_addr_o); end
    n_cmp++; if (aen_pulses !== 64 || aen_bad !== 0) begin n_bad++; $display("FAIL word3_aen: pulses %0d badlen %0d want 64/0", aen_pulses, aen_bad); end
  endtask

  task automatic test_trd_zero();
    int lat; logic d1, b1;
    fuse_word1();
    run_read(2'd1, 10'd0, 1, 0, 0, lat, d1, b1);
    n_cmp++; if (lat !== 322) begin n_bad++; $display("FAIL trd0_latency: got %0d want 322", lat); end
    n_cmp++; if (read_data !== 64'h8000_0010_0000_0003) begin n_bad++; $display("FAIL trd0_data: got %h want 8000001000000003", read_data); end
    n_cmp++; if (aen_pulses !== 64 || aen_bad !== 0) begin n_bad++; $display("FAIL trd0_aen: pulses %0d badlen %0d want 64/0", aen_pulses, aen_bad); end
  endtask

  task automatic test_back_to_back();
    int lat; logic d1, b1;
    fuse_word0();
    n_cmp++; if (read_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_before: got %b want 1", read_done); end
    run_read(2'd0, 10'd0, 1, 0, 0, lat, d1, b1);
    n_cmp++; if (d1 !== 1'b0 || b1 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: done %b busy %b want 0/1", d1, b1); end
    n_cmp++; if (lat !== 322 || read_data !== 64'h8000_0000_0000_0021) begin n_bad++; $display("FAIL b2b_result: lat %0d data %h want 322/8000000000000021", lat, read_data); end
  endtask

  task automatic test_start_while_busy();
    int lat; logic d1, b1;
    fuse_word1();
    run_read(2'd1, 10'd2, 2, 0, 50, lat, d1, b1);
    repeat (20) @(negedge clk);
    n_cmp++; if (lat !== 386) begin n_bad++; $display("FAIL busy_start_latency: got %0d want 386", lat); end
    n_cmp++; if (addr_min !== 64 || addr_max !== 127) begin n_bad++; $display("FAIL busy_start_addr_range: got %0d..%0d want 64..127", addr_min, addr_max); end
    n_cmp++; if (done_rises !== 1 || busy_read !== 1'b0) begin n_bad++; $display("FAIL busy_start_single: done rises %0d busy %b want 1/0", done_rises, busy_read); end
    n_cmp++; if (read_data !== 64'h8000_0010_0000_0003) begin n_bad++; $display("FAIL busy_start_data: got %h want 8000001000000003", read_data); end
  endtask

  task automatic test_reset_mid_read();
    int lat; logic d1, b1;
    fuse_word0();
    run_read(2'd0, 10'd2, 2, 100, 0, lat, d1, b1);
    n_cmp++; if (read_data === 64'd0) begin n_bad++; $display("FAIL midrst_pre_data: got %h want nonzero partial word", read_data); end
    @(posedge clk);
    #1;
    n_cmp++; if ({busy_read, efuse_aen_o, efuse_rden_o} !== 3'b000) begin n_bad++; $display("FAIL midrst_pins: busy/aen/rden got %b want 000", {busy_read, efuse_aen_o, efuse_rden_o}); end
    n_cmp++; if (efuse_addr_o !== 8'd0 || read_data !== 64'd0 || read_done !== 1'b0) begin n_bad++; $display("FAIL midrst_state: addr %0d data %h done %b want 0/0/0", efuse_addr_o, read_data, read_done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (read_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got %b want 0", read_done); end
    wait_idle();
    run_read(2'd0, 10'd2, 2, 0, 0, lat, d1, b1);
    n_cmp++; if (lat !== 386 || read_data !== 64'h8000_0000_0000_0021) begin n_bad++; $display("FAIL midrst_reread: lat %0d data %h want 386/8000000000000021", lat, read_data); end
  endtask

  initial begin
    test_reset();
`ifdef EFUSE_RD_AUTOLOAD_EN
    test_autoload();
`else
    test_no_autoload();
`endif
    test_read_word0();
    test_read_word3();
    test_trd_zero();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
